// File: rtl/game_round_scheduler_pkg.sv
// Shared types and widths for the hole-in-the-wall game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_ADVANCE   = 3'd2,
    ST_RESULT    = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam int DEPTH_W     = 8;
  localparam int IDX_W       = 4;
  localparam int SCORE_W     = 16;
  localparam int ROUND_W     = 8;
  localparam int LIVES_W     = 2;
  localparam int FPT_W       = 4;
  localparam int FRAME_CNT_W = 8;
  localparam int SPD_W       = 8;

endpackage

// File: rtl/game_round_scheduler_frame_tick_divider.sv
// Divides the frame pulse stream by a run-time frames-per-tick value.
module frame_tick_divider
  import game_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             frame,
  input  logic [FPT_W-1:0] frames_per_tick,
  output logic             tick
);

  logic [FPT_W-1:0] cnt;
  logic             at_max;

  // >= rather than == so a speed-up never strands the count above the new limit
  assign at_max = (cnt >= (frames_per_tick - 1'b1));
  assign tick   = frame && at_max;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (frame) begin
      cnt <= at_max ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_round_scheduler.sv
// Whole-game sequencer: countdown, wall advance, goal-window judging, scoring,
// lives, wall selection and speed-up.
module game_round_scheduler
  import game_pkg::*;
#(
  parameter int MAX_WALL_DEPTH      = 75,
  parameter int GOAL_DEPTH          = 60,
  parameter int GOAL_DEPTH_DELTA    = 10,
  parameter int NUM_WALLS           = 10,
  parameter int MAX_FRAMES_PER_TICK = 15,
  parameter int MIN_FRAMES_PER_TICK = 3,
  parameter int SPEEDUP_EVERY       = 2,
  parameter int COUNTDOWN_FRAMES    = 180,
  parameter int RESULT_FRAMES       = 120,
  parameter int START_LIVES         = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_game_in,
  input  logic               new_frame_in,
  input  logic               collision_in,
  output logic [2:0]         game_state_out,
  output logic [DEPTH_W-1:0] wall_depth_out,
  output logic [IDX_W-1:0]   wall_idx_out,
  output logic [ROUND_W-1:0] round_out,
  output logic [SCORE_W-1:0] score_out,
  output logic [LIVES_W-1:0] lives_out,
  output logic [FPT_W-1:0]   frames_per_tick_out,
  output logic               round_pass_out,
  output logic               round_fail_out
);

  localparam logic [DEPTH_W-1:0]     LAST_DEPTH = DEPTH_W'(MAX_WALL_DEPTH - 1);
  localparam logic [DEPTH_W-1:0]     WIN_LO     = DEPTH_W'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
  localparam logic [DEPTH_W-1:0]     WIN_HI     = DEPTH_W'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_WALLS - 1);
  localparam logic [FPT_W-1:0]       FPT_MAX    = FPT_W'(MAX_FRAMES_PER_TICK);
  localparam logic [FPT_W-1:0]       FPT_MIN    = FPT_W'(MIN_FRAMES_PER_TICK);
  localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [FRAME_CNT_W-1:0] CD_LOAD    = FRAME_CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] RES_LOAD   = FRAME_CNT_W'(RESULT_FRAMES);
  localparam logic [SPD_W-1:0]       SPD_LAST   = SPD_W'(SPEEDUP_EVERY - 1);
  localparam logic [SCORE_W:0]       PASS_BASE  = (SCORE_W + 1)'(MAX_FRAMES_PER_TICK + 1);

  game_state_t            state_r, state_nxt;
  logic [DEPTH_W-1:0]     depth_r, depth_nxt;
  logic [IDX_W-1:0]       idx_r, idx_nxt;
  logic [ROUND_W-1:0]     round_r, round_nxt;
  logic [SCORE_W-1:0]     score_r, score_nxt;
  logic [LIVES_W-1:0]     lives_r, lives_nxt;
  logic [FPT_W-1:0]       fpt_r, fpt_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_nxt;
  logic [SPD_W-1:0]       spd_cnt_r, spd_cnt_nxt;
  logic                   hit_r, hit_nxt;
  logic                   pass_r, pass_nxt;
  logic                   fail_r, fail_nxt;
  logic                   tick;
  logic                   in_window;
  logic                   hit_now;

  // Faster walls earn more per round; the sum is clamped rather than wrapped.
  function automatic logic [SCORE_W-1:0] sat_score_add(input logic [SCORE_W-1:0] score,
                                                       input logic [FPT_W-1:0]   fpt);
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + PASS_BASE - {{(SCORE_W + 1 - FPT_W){1'b0}}, fpt};
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [ROUND_W-1:0] sat_round_inc(input logic [ROUND_W-1:0] round);
    return (round == '1) ? round : round + 1'b1;
  endfunction

  frame_tick_divider u_divider (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clr             (state_r != ST_ADVANCE),
    .frame           (new_frame_in),
    .frames_per_tick (fpt_r),
    .tick            (tick)
  );

  assign in_window = (depth_r >= WIN_LO) && (depth_r <= WIN_HI);
  assign hit_now   = collision_in && in_window;

  always_comb begin
    state_nxt     = state_r;
    depth_nxt     = depth_r;
    idx_nxt       = idx_r;
    round_nxt     = round_r;
    score_nxt     = score_r;
    lives_nxt     = lives_r;
    fpt_nxt       = fpt_r;
    frame_cnt_nxt = frame_cnt_r;
    spd_cnt_nxt   = spd_cnt_r;
    hit_nxt       = hit_r;
    pass_nxt      = 1'b0;
    fail_nxt      = 1'b0;

    case (state_r)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_game_in) begin
          state_nxt     = ST_COUNTDOWN;
          depth_nxt     = '0;
          idx_nxt       = '0;
          round_nxt     = '0;
          score_nxt     = '0;
          lives_nxt     = LIVES_INIT;
          fpt_nxt       = FPT_MAX;
          frame_cnt_nxt = CD_LOAD;
          spd_cnt_nxt   = '0;
          hit_nxt       = 1'b0;
        end
      end

      ST_COUNTDOWN: begin
        if (new_frame_in) begin
          if (frame_cnt_r <= 1) begin
            state_nxt = ST_ADVANCE;
            depth_nxt = '0;
            hit_nxt   = 1'b0;
          end else begin
            frame_cnt_nxt = frame_cnt_r - 1'b1;
          end
        end
      end

      ST_ADVANCE: begin
        if (hit_now) hit_nxt = 1'b1;
        if (tick) begin
          if (depth_r == LAST_DEPTH) begin
            state_nxt     = ST_RESULT;
            frame_cnt_nxt = RES_LOAD;
            // A collision on the final tick still belongs to this round
            if (hit_r || hit_now) begin
              fail_nxt  = 1'b1;
              lives_nxt = (lives_r != '0) ? lives_r - 1'b1 : lives_r;
            end else begin
              pass_nxt  = 1'b1;
              score_nxt = sat_score_add(score_r, fpt_r);
              if (spd_cnt_r >= SPD_LAST) begin
                spd_cnt_nxt = '0;
                if (fpt_r > FPT_MIN) fpt_nxt = fpt_r - 1'b1;
              end else begin
                spd_cnt_nxt = spd_cnt_r + 1'b1;
              end
            end
          end else begin
            depth_nxt = depth_r + 1'b1;
          end
        end
      end

      ST_RESULT: begin
        if (new_frame_in) begin
          if (frame_cnt_r <= 1) begin
            if (lives_r == '0) begin
              state_nxt = ST_GAME_OVER;
            end else begin
              state_nxt = ST_ADVANCE;
              round_nxt = sat_round_inc(round_r);
              idx_nxt   = (idx_r >= LAST_IDX) ? '0 : idx_r + 1'b1;
              depth_nxt = '0;
              hit_nxt   = 1'b0;
            end
          end else begin
            frame_cnt_nxt = frame_cnt_r - 1'b1;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= ST_IDLE;
      depth_r     <= '0;
      idx_r       <= '0;
      round_r     <= '0;
      score_r     <= '0;
      lives_r     <= LIVES_INIT;
      fpt_r       <= FPT_MAX;
      frame_cnt_r <= '0;
      spd_cnt_r   <= '0;
      hit_r       <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      depth_r     <= depth_nxt;
      idx_r       <= idx_nxt;
      round_r     <= round_nxt;
      score_r     <= score_nxt;
      lives_r     <= lives_nxt;
      fpt_r       <= fpt_nxt;
      frame_cnt_r <= frame_cnt_nxt;
      spd_cnt_r   <= spd_cnt_nxt;
      hit_r       <= hit_nxt;
      pass_r      <= pass_nxt;
      fail_r      <= fail_nxt;
    end
  end

  assign game_state_out      = state_r;
  assign wall_depth_out      = depth_r;
  assign wall_idx_out        = idx_r;
  assign round_out           = round_r;
  assign score_out           = score_r;
  assign lives_out           = lives_r;
  assign frames_per_tick_out = fpt_r;
  assign round_pass_out      = pass_r;
  assign round_fail_out      = fail_r;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Randomized bench for game_round_scheduler against a rule-level game model.
module tb_game_round_scheduler;

  localparam int MAXD    = 8;
  localparam int GOAL    = 5;
  localparam int DELTA   = 1;
  localparam int NWALLS  = 10;
  localparam int MAXF    = 2;
  localparam int MINF    = 1;
  localparam int SPEEDUP = 1;
  localparam int CD      = 3;
  localparam int RES     = 2;
  localparam int LIVES   = 2;

  localparam int S_IDLE = 0, S_CD = 1, S_ADV = 2, S_RES = 3, S_OVER = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_game_in = 1'b0;
  logic        new_frame_in = 1'b0;
  logic        collision_in = 1'b0;
  logic [2:0]  game_state_out;
  logic [7:0]  wall_depth_out;
  logic [3:0]  wall_idx_out;
  logic [7:0]  round_out;
  logic [15:0] score_out;
  logic [1:0]  lives_out;
  logic [3:0]  frames_per_tick_out;
  logic        round_pass_out;
  logic        round_fail_out;

  game_round_scheduler #(
    .MAX_WALL_DEPTH(MAXD), .GOAL_DEPTH(GOAL), .GOAL_DEPTH_DELTA(DELTA), .NUM_WALLS(NWALLS),
    .MAX_FRAMES_PER_TICK(MAXF), .MIN_FRAMES_PER_TICK(MINF), .SPEEDUP_EVERY(SPEEDUP),
    .COUNTDOWN_FRAMES(CD), .RESULT_FRAMES(RES), .START_LIVES(LIVES)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_game_in(start_game_in),
    .new_frame_in(new_frame_in), .collision_in(collision_in),
    .game_state_out(game_state_out), .wall_depth_out(wall_depth_out),
    .wall_idx_out(wall_idx_out), .round_out(round_out), .score_out(score_out),
    .lives_out(lives_out), .frames_per_tick_out(frames_per_tick_out),
    .round_pass_out(round_pass_out), .round_fail_out(round_fail_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: whole-round bookkeeping in plain integers.
  int m_state, m_depth, m_idx, m_round, m_score, m_lives, m_fpt;
  int m_pass, m_fail, m_hit, m_left, m_frames_at_depth, m_passes;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    $display("FAIL %s: cycle budget expired at %0t", tag, $time);
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_depth = 0; m_idx = 0; m_round = 0; m_score = 0;
    m_lives = LIVES; m_fpt = MAXF; m_pass = 0; m_fail = 0; m_hit = 0;
    m_left = 0; m_frames_at_depth = 0; m_passes = 0;
  endtask

  task automatic model_end_round();
    m_state = S_RES;
    m_left  = RES;
    if (m_hit != 0) begin
      m_fail  = 1;
      m_lives = m_lives - 1;
    end else begin
      m_pass   = 1;
      m_score  = m_score + (MAXF + 1 - m_fpt);
      if (m_score > 65535) m_score = 65535;
      m_passes = m_passes + 1;
      if ((m_passes % SPEEDUP) == 0 && m_fpt > MINF) m_fpt = m_fpt - 1;
    end
  endtask

  task automatic model_step(input bit s, input bit f, input bit c);
    m_pass = 0;
    m_fail = 0;
    case (m_state)
      S_IDLE, S_OVER: begin
        if (s) begin
          model_reset();
          m_state = S_CD;
          m_left  = CD;
        end
      end
      S_CD: begin
        if (f) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_state = S_ADV; m_depth = 0; m_frames_at_depth = 0; m_hit = 0;
          end
        end
      end
      S_ADV: begin
        if (c && m_depth >= GOAL - DELTA && m_depth <= GOAL + DELTA) m_hit = 1;
        if (f) begin
          m_frames_at_depth = m_frames_at_depth + 1;
          if (m_frames_at_depth == m_fpt) begin
            m_frames_at_depth = 0;
            if (m_depth == MAXD - 1) model_end_round();
            else m_depth = m_depth + 1;
          end
        end
      end
      S_RES: begin
        if (f) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_lives == 0) begin
              m_state = S_OVER;
            end else begin
              m_round = (m_round < 255) ? m_round + 1 : 255;
              m_idx   = (m_idx + 1) % NWALLS;
              m_depth = 0; m_frames_at_depth = 0; m_hit = 0;
              m_state = S_ADV;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("state", int'(game_state_out), m_state);
    check("depth", int'(wall_depth_out), m_depth);
    check("idx",   int'(wall_idx_out), m_idx);
    check("round", int'(round_out), m_round);
    check("score", int'(score_out), m_score);
    check("lives", int'(lives_out), m_lives);
    check("fpt",   int'(frames_per_tick_out), m_fpt);
    check("pass",  int'(round_pass_out), m_pass);
    check("fail",  int'(round_fail_out), m_fail);
  endtask

  task automatic drive(input bit s, input bit f, input bit c);
    start_game_in = s;
    new_frame_in  = f;
    collision_in  = c;
    @(posedge clk_in);
    model_step(s, f, c);
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic start_game();
    bit done;
    done = 0;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !done; i++) begin
      drive(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if (m_state == S_ADV) done = 1;
    end
    if (!done) timeout_fail("countdown");
  endtask

  // Plays from ADVANCE until the model leaves RESULT. coll_depth < 0 means no collisions.
  task automatic run_round(input int coll_depth, input bit on_tick, input bit rnd_start);
    bit seen_res, done, f, c, s;
    seen_res = 0;
    done     = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      f = ($urandom_range(0, 2) != 0);
      c = 1'b0;
      s = rnd_start && ($urandom_range(0, 3) == 0);
      if (m_state == S_ADV && m_depth == coll_depth) begin
        if (on_tick) c = f && (m_frames_at_depth + 1 >= m_fpt);
        else         c = 1'b1;
      end
      drive(s, f, c);
      if (m_state == S_RES) seen_res = 1;
      else if (seen_res) done = 1;
    end
    if (!done) timeout_fail("round");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk_in);
    check_outputs();
    rst_in = 1'b1;
    drive(1'b0, 1'b1, 1'b1);

    // First game: clean pass, ignored out-of-window hit, in-window fail, edge hit on tick
    start_game();
    run_round(-1, 1'b0, 1'b0);
    run_round(3, 1'b0, 1'b0);
    run_round(5, 1'b0, 1'b0);
    run_round(6, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b1, 1'b1);
    check("game_over", int'(game_state_out), S_OVER);

    // Restart from GAME_OVER; twelve rounds wrap the wall index
    start_game();
    run_round(7, 1'b1, 1'b1);
    for (int r = 0; r < 11; r++) run_round(-1, 1'b0, 1'b1);
    check("idx_wrapped", int'(wall_idx_out), 12 % NWALLS);

    // Preload a near-max score and let two passes saturate it
    force dut.score_r = 16'hFFFE;
    m_score = 16'hFFFE;
    drive(1'b0, 1'b0, 1'b0);
    release dut.score_r;
    run_round(-1, 1'b0, 1'b0);
    run_round(-1, 1'b0, 1'b0);
    check("score_sat", int'(score_out), 65535);

    // Asynchronous reset in the middle of a wall's travel
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    start_game_in = 1'b0; new_frame_in = 1'b0; collision_in = 1'b0;
    #2 rst_in = 1'b0;
    #1 model_reset();
    check_outputs();
    @(negedge clk_in);
    check_outputs();
    rst_in = 1'b1;

    // Free-running random play with occasional restarts
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
